// File: rtl/gpio_bank_pkg.sv
// Shared opcode/state encodings and command field positions for the GPIO bank controller.
package gpio_bank_pkg;

  typedef enum logic [3:0] {
    OP_WR_OUT    = 4'd0,
    OP_WR_OE     = 4'd1,
    OP_SET       = 4'd2,
    OP_CLR       = 4'd3,
    OP_TGL       = 4'd4,
    OP_RD_IN     = 4'd5,
    OP_WR_EMASK  = 4'd6,
    OP_RD_EDGE   = 4'd7,
    OP_WAIT_EDGE = 4'd8
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RESP = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  // Field MSBs are given as offsets below DATABITWIDTH (opcode at DW-1, channel at DW-5).
  localparam int unsigned OPC_W       = 4;
  localparam int unsigned CH_W        = 4;
  localparam int unsigned OPC_TOP_OFS = 1;
  localparam int unsigned CH_TOP_OFS  = 5;
  localparam logic [3:0]  OPC_MAX     = 4'd8;

endpackage

// File: rtl/gpio_bank_channel.sv
// One GPIO channel: OUT/OE/EMASK registers, 2-flop input synchroniser and sticky rising-edge capture.
module gpio_bank_channel
  import gpio_bank_pkg::*;
#(
  parameter int unsigned PORTWIDTH = 8
) (
  input  logic                 clk,
  input  logic                 async_rst_n,
  input  logic                 i_we,
  input  logic [OPC_W-1:0]     i_opc,
  input  logic [PORTWIDTH-1:0] i_payload,
  input  logic                 i_rd_clr,
  input  logic                 i_wait_clr,
  input  logic [PORTWIDTH-1:0] i_pin,
  output logic [PORTWIDTH-1:0] o_out,
  output logic [PORTWIDTH-1:0] o_oe,
  output logic [PORTWIDTH-1:0] o_emask,
  output logic [PORTWIDTH-1:0] o_out_nxt,
  output logic [PORTWIDTH-1:0] o_oe_nxt,
  output logic [PORTWIDTH-1:0] o_emask_nxt,
  output logic [PORTWIDTH-1:0] o_sync,
  output logic [PORTWIDTH-1:0] o_sticky,
  output logic [PORTWIDTH-1:0] o_pend
);

  logic [PORTWIDTH-1:0] r_out, r_oe, r_emask, r_meta, r_sync, r_prev, r_sticky;
  logic [PORTWIDTH-1:0] w_out_nxt, w_oe_nxt, w_emask_nxt, w_rise, w_sticky_d;

  always_comb begin
    w_out_nxt   = r_out;
    w_oe_nxt    = r_oe;
    w_emask_nxt = r_emask;
    case (i_opc)
      OP_WR_OUT:   w_out_nxt   = i_payload;
      OP_WR_OE:    w_oe_nxt    = i_payload;
      OP_SET:      w_out_nxt   = r_out | i_payload;
      OP_CLR:      w_out_nxt   = r_out & ~i_payload;
      OP_TGL:      w_out_nxt   = r_out ^ i_payload;
      OP_WR_EMASK: w_emask_nxt = i_payload;
      default: ;
    endcase
  end

  assign w_rise = r_sync & ~r_prev & r_emask;

  // A read-clear keeps an edge arriving in the same cycle; a wait-clear already reported it.
  always_comb begin
    w_sticky_d = r_sticky | w_rise;
    if (i_wait_clr) begin
      w_sticky_d = '0;
    end else if (i_rd_clr) begin
      w_sticky_d = w_rise;
    end
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      r_out    <= '0;
      r_oe     <= '0;
      r_emask  <= '0;
      r_meta   <= '0;
      r_sync   <= '0;
      r_prev   <= '0;
      r_sticky <= '0;
    end else begin
      r_meta   <= i_pin;
      r_sync   <= r_meta;
      r_prev   <= r_sync;
      r_sticky <= w_sticky_d;
      if (i_we) begin
        r_out   <= w_out_nxt;
        r_oe    <= w_oe_nxt;
        r_emask <= w_emask_nxt;
      end
    end
  end

  assign o_out       = r_out;
  assign o_oe        = r_oe;
  assign o_emask     = r_emask;
  assign o_out_nxt   = w_out_nxt;
  assign o_oe_nxt    = w_oe_nxt;
  assign o_emask_nxt = w_emask_nxt;
  assign o_sync      = r_sync;
  assign o_sticky    = r_sticky;
  assign o_pend      = r_sticky | w_rise;

endmodule

// File: rtl/gpio_bank_controller.sv
// GPIO bank controller: decodes IO-bus commands, drives per-channel registers, returns responses.
module gpio_bank_controller
  import gpio_bank_pkg::*;
#(
  parameter int unsigned DATABITWIDTH = 16,
  parameter int unsigned PORTWIDTH    = 8,
  parameter int unsigned CHANNELS     = 4
) (
  input  logic                          clk,
  input  logic                          async_rst_n,
  input  logic                          IOOut_REQ,
  output logic                          IOOut_ACK,
  input  logic                          IOOut_ResponseRequested,
  input  logic [3:0]                    IOOut_DestReg,
  input  logic [DATABITWIDTH-1:0]       IOOut_Data,
  output logic                          IOIn_REQ,
  input  logic                          IOIn_ACK,
  output logic                          IOIn_RegResponseFlag,
  output logic                          IOIn_MemResponseFlag,
  output logic [3:0]                    IOIn_DestReg,
  output logic [DATABITWIDTH-1:0]       IOIn_Data,
  input  logic [CHANNELS*PORTWIDTH-1:0] GPIO_DIn,
  output logic [CHANNELS*PORTWIDTH-1:0] GPIO_DOut,
  output logic [CHANNELS*PORTWIDTH-1:0] GPIO_DOutEn
);

  localparam int unsigned PAD_W = DATABITWIDTH - PORTWIDTH;

  state_e                  r_state, w_state_d;
  logic [DATABITWIDTH-1:0] r_data, w_data_d;
  logic [3:0]              r_dest, w_dest_d;
  logic [CH_W-1:0]         r_wait_ch, w_wait_ch_d;

  logic [OPC_W-1:0]     w_opc;
  logic [CH_W-1:0]      w_ch;
  logic [PORTWIDTH-1:0] w_payload, w_resp_val, w_wait_val;
  logic                 w_accept, w_ch_ok, w_legal, w_wait_hit;
  logic [CHANNELS-1:0]  w_sel, w_we, w_rd_clr, w_wait_clr;

  logic [PORTWIDTH-1:0] w_out[CHANNELS], w_oe[CHANNELS], w_emask[CHANNELS];
  logic [PORTWIDTH-1:0] w_out_nxt[CHANNELS], w_oe_nxt[CHANNELS], w_emask_nxt[CHANNELS];
  logic [PORTWIDTH-1:0] w_sync[CHANNELS], w_sticky[CHANNELS], w_pend[CHANNELS];

  assign w_opc     = IOOut_Data[DATABITWIDTH-OPC_TOP_OFS -: OPC_W];
  assign w_ch      = IOOut_Data[DATABITWIDTH-CH_TOP_OFS -: CH_W];
  assign w_payload = IOOut_Data[PORTWIDTH-1:0];

  if (DATABITWIDTH > PORTWIDTH + 8) begin : g_unused
    logic w_unused_mid;
    assign w_unused_mid = ^IOOut_Data[DATABITWIDTH-9:PORTWIDTH];
  end

  // Reset gates ACK so no command can be accepted while the bank is held in reset.
  assign IOOut_ACK = (r_state == ST_IDLE) && async_rst_n;
  assign w_accept  = IOOut_REQ && IOOut_ACK;
  assign w_ch_ok   = {{(32-CH_W){1'b0}}, w_ch} < CHANNELS;
  assign w_legal   = (w_opc <= OPC_MAX) && w_ch_ok;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    assign w_sel[c]      = (w_ch == CH_W'(c));
    assign w_we[c]       = w_accept && w_legal && w_sel[c];
    assign w_rd_clr[c]   = w_we[c] && (w_opc == OP_RD_EDGE);
    assign w_wait_clr[c] = (r_state == ST_WAIT) && w_wait_hit && (r_wait_ch == CH_W'(c));

    gpio_bank_channel #(
      .PORTWIDTH(PORTWIDTH)
    ) u_channel (
      .clk        (clk),
      .async_rst_n(async_rst_n),
      .i_we       (w_we[c]),
      .i_opc      (w_opc),
      .i_payload  (w_payload),
      .i_rd_clr   (w_rd_clr[c]),
      .i_wait_clr (w_wait_clr[c]),
      .i_pin      (GPIO_DIn[c*PORTWIDTH +: PORTWIDTH]),
      .o_out      (w_out[c]),
      .o_oe       (w_oe[c]),
      .o_emask    (w_emask[c]),
      .o_out_nxt  (w_out_nxt[c]),
      .o_oe_nxt   (w_oe_nxt[c]),
      .o_emask_nxt(w_emask_nxt[c]),
      .o_sync     (w_sync[c]),
      .o_sticky   (w_sticky[c]),
      .o_pend     (w_pend[c])
    );

    assign GPIO_DOut[c*PORTWIDTH +: PORTWIDTH]   = w_out[c];
    assign GPIO_DOutEn[c*PORTWIDTH +: PORTWIDTH] = w_oe[c];
  end

  always_comb begin
    w_resp_val = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (w_sel[c]) begin
        case (w_opc)
          OP_WR_OUT, OP_SET, OP_CLR, OP_TGL: w_resp_val = w_out_nxt[c];
          OP_WR_OE:    w_resp_val = w_oe_nxt[c];
          OP_WR_EMASK: w_resp_val = w_emask_nxt[c];
          OP_RD_IN:    w_resp_val = w_sync[c];
          OP_RD_EDGE:  w_resp_val = w_sticky[c];
          default:     w_resp_val = '0;
        endcase
      end
    end
  end

  always_comb begin
    w_wait_val = '0;
    w_wait_hit = 1'b0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (r_wait_ch == CH_W'(c)) begin
        w_wait_val = w_pend[c];
        w_wait_hit = |(w_pend[c] & w_emask[c]);
      end
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_data_d    = r_data;
    w_dest_d    = r_dest;
    w_wait_ch_d = r_wait_ch;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_dest_d = IOOut_DestReg;
          if (w_legal && (w_opc == OP_WAIT_EDGE)) begin
            w_state_d   = ST_WAIT;
            w_wait_ch_d = w_ch;
          end else if (IOOut_ResponseRequested) begin
            w_state_d = ST_RESP;
            w_data_d  = w_legal ? {{PAD_W{1'b0}}, w_resp_val} : '0;
          end
        end
      end
      ST_WAIT: begin
        if (w_wait_hit) begin
          w_state_d = ST_RESP;
          w_data_d  = {{PAD_W{1'b0}}, w_wait_val};
        end
      end
      ST_RESP: begin
        if (IOIn_ACK) w_state_d = ST_IDLE;
      end
      default: w_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      r_state   <= ST_IDLE;
      r_data    <= '0;
      r_dest    <= '0;
      r_wait_ch <= '0;
    end else begin
      r_state   <= w_state_d;
      r_data    <= w_data_d;
      r_dest    <= w_dest_d;
      r_wait_ch <= w_wait_ch_d;
    end
  end

  assign IOIn_REQ             = (r_state == ST_RESP);
  assign IOIn_RegResponseFlag = IOIn_REQ;
  assign IOIn_MemResponseFlag = 1'b0;
  assign IOIn_DestReg         = r_dest;
  assign IOIn_Data            = r_data;

endmodule
